// File: rtl/prefetch_queue.sv
// prefetch_queue: byte-granular instruction prefetch buffer.
//
// Fetches aligned 32-bit words from instruction memory ahead of execution and
// queues them as bytes. Decode sees the next four bytes on ope (head byte in
// [31:24]) and retires 1..4 bytes per cycle. A taken jump flushes the queue and
// restarts fetching at the new address.
//
// Parameters
//   DEPTH       queue capacity in bytes (power of 2, >= 8)
//   RESET_ADDR  eip after reset
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-low reset
//   mem_req/mem_addr  word read request (held until mem_ack), word-aligned address
//   mem_ack/mem_data  response strobe and word, byte at mem_addr+0 in [31:24]
//   ope/ope_valid     next 4 queued bytes (registered), valid when count >= 4
//   eip               address of the head byte
//   consume/num_of_ope retire num_of_ope bytes (1..4)
//   redirect/redirect_eip flush and restart at redirect_eip
//   consume_err       1-cycle pulse after an illegal (ignored) consume
//
// Optional build macro PREFETCH_STATS_EN adds stall_cnt and flush_cnt outputs.
module prefetch_queue #(
  parameter int unsigned DEPTH      = 16,
  parameter logic [31:0] RESET_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data,
  output logic [31:0] ope,
  output logic        ope_valid,
  output logic [31:0] eip,
  input  logic        consume,
  input  logic [3:0]  num_of_ope,
  input  logic        redirect,
  input  logic [31:0] redirect_eip,
  output logic        consume_err
`ifdef PREFETCH_STATS_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {StIdle, StReq, StDiscard} state_e;

  state_e        state_q, state_d;
  logic [7:0]    buf_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   eip_q, eip_d;
  logic [31:0]   fetch_ptr_q, fetch_ptr_d;
  logic [1:0]    skip_q, skip_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic [31:0]   ope_q, ope_d;
  logic          ope_valid_q;
  logic          consume_err_q;

  logic          legal;
  logic          ack_wr;
  logic [2:0]    wr_cnt;
  logic [CW-1:0] free;

  always_comb begin
    legal  = consume && (num_of_ope != 4'd0) && (num_of_ope <= 4'd4) &&
             (CW'(num_of_ope) <= count_q);
    // Ack data is dropped when a redirect lands in the same cycle.
    ack_wr = (state_q == StReq) && mem_ack && !redirect;
    wr_cnt = 3'd4 - {1'b0, skip_q};
    free   = CW'(DEPTH) - count_q;

    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    eip_d       = eip_q;
    fetch_ptr_d = fetch_ptr_q;
    skip_d      = skip_q;

    if (redirect) begin
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      eip_d       = redirect_eip;
      fetch_ptr_d = {redirect_eip[31:2], 2'b00};
      skip_d      = redirect_eip[1:0];
    end else begin
      if (ack_wr) begin
        tail_d      = tail_q + PW'(wr_cnt);
        fetch_ptr_d = fetch_ptr_q + 32'd4;
        skip_d      = 2'd0;
      end
      if (legal) begin
        head_d = head_q + PW'(num_of_ope);
        eip_d  = eip_q + 32'(num_of_ope);
      end
      count_d = count_q + (ack_wr ? CW'(wr_cnt) : CW'(0)) - (legal ? CW'(num_of_ope) : CW'(0));
    end

    state_d    = state_q;
    req_addr_d = req_addr_q;
    unique case (state_q)
      StIdle: begin
        if (!redirect && (free >= CW'(4))) begin
          state_d    = StReq;
          req_addr_d = fetch_ptr_q;
        end
      end
      StReq: begin
        if (mem_ack)       state_d = StIdle;
        else if (redirect) state_d = StDiscard;
      end
      StDiscard: begin
        if (mem_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Window is taken from the registered queue state, so it trails updates by a cycle.
    ope_d = '0;
    for (int k = 0; k < 4; k++) begin
      if (CW'(k) < count_q) ope_d[31-8*k -: 8] = buf_q[head_q + PW'(k)];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StIdle;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      eip_q         <= RESET_ADDR;
      fetch_ptr_q   <= {RESET_ADDR[31:2], 2'b00};
      skip_q        <= RESET_ADDR[1:0];
      req_addr_q    <= {RESET_ADDR[31:2], 2'b00};
      ope_q         <= '0;
      ope_valid_q   <= 1'b0;
      consume_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      eip_q         <= eip_d;
      fetch_ptr_q   <= fetch_ptr_d;
      skip_q        <= skip_d;
      req_addr_q    <= req_addr_d;
      ope_q         <= ope_d;
      ope_valid_q   <= (count_q >= CW'(4));
      consume_err_q <= consume && !legal;
    end
  end

  // Byte storage needs no reset; bytes beyond count are masked on read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (reset && ack_wr && (i >= int'(skip_q))) begin
        buf_q[tail_q + PW'(i) - PW'(skip_q)] <= mem_data[31-8*i -: 8];
      end
    end
  end

  assign mem_req     = (state_q != StIdle);
  assign mem_addr    = req_addr_q;
  assign ope         = ope_q;
  assign ope_valid   = ope_valid_q;
  assign eip         = eip_q;
  assign consume_err = consume_err_q;

`ifdef PREFETCH_STATS_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!ope_valid_q && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (redirect && (flush_cnt_q != 32'hFFFF_FFFF))     flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_prefetch_queue.sv
// Self-checking bench for prefetch_queue (DEPTH=16, RESET_ADDR=0): reset state,
// first-word latency, fill/full, consume table incl. illegal cases, redirect
// with unaligned target, and redirect during an outstanding request.
module tb_prefetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_data = 32'h0;
  logic [31:0] ope;
  logic        ope_valid;
  logic [31:0] eip;
  logic        consume;
  logic [3:0]  num_of_ope;
  logic        redirect;
  logic [31:0] redirect_eip;
  logic        consume_err;
`ifdef PREFETCH_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  int total = 0;
  int bad   = 0;
  logic resp_en = 1'b1;
  int   ack_delay = 0;
  int   wcnt = 0;

  always #5 clk = ~clk;

  prefetch_queue #(.DEPTH(16), .RESET_ADDR(32'h0)) dut (
    .clk(clk),
    .reset(reset),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ack(mem_ack),
    .mem_data(mem_data),
    .ope(ope),
    .ope_valid(ope_valid),
    .eip(eip),
    .consume(consume),
    .num_of_ope(num_of_ope),
    .redirect(redirect),
    .redirect_eip(redirect_eip),
    .consume_err(consume_err)
`ifdef PREFETCH_STATS_EN
    ,
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h8B5D0855;
      32'd4:   return 32'h89E5C3AA;
      32'd8:   return 32'h11223344;
      32'd12:  return 32'h55667788;
      default: return {a[7:0], a[7:0] + 8'd1, a[7:0] + 8'd2, a[7:0] + 8'd3};
    endcase
  endfunction

  // Memory model: acks after ack_delay waiting cycles.
  always @(negedge clk) begin
    if (mem_req && resp_en) begin
      if (wcnt >= ack_delay) begin
        mem_ack  = 1'b1;
        mem_data = word_at(mem_addr);
        wcnt     = 0;
      end else begin
        mem_ack = 1'b0;
        wcnt    = wcnt + 1;
      end
    end else begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input int lim);
    int n = 0;
    while (!ope_valid && n < lim) begin
      step();
      n++;
    end
    check("wait_ope_valid", {31'b0, ope_valid}, 32'd1);
  endtask

  task automatic wait_req(input logic lvl, input int lim);
    int n = 0;
    while (mem_req !== lvl && n < lim) begin
      step();
      n++;
    end
    check("wait_mem_req", {31'b0, mem_req}, {31'b0, lvl});
  endtask

  typedef struct {
    logic        c;
    logic [3:0]  n;
    logic        err;
    logic [31:0] eip;
    logic [31:0] ope;
    logic        valid;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Queue holds bytes 0..15 when the table starts.
    vecs[0] = '{1'b1, 4'd2, 1'b0, 32'd2,  32'h085589E5, 1'b1};
    vecs[1] = '{1'b1, 4'd0, 1'b1, 32'd2,  32'h085589E5, 1'b1};
    vecs[2] = '{1'b1, 4'd5, 1'b1, 32'd2,  32'h085589E5, 1'b1};
    vecs[3] = '{1'b1, 4'd4, 1'b0, 32'd6,  32'hC3AA1122, 1'b1};
    vecs[4] = '{1'b1, 4'd4, 1'b0, 32'd10, 32'h33445566, 1'b1};
    vecs[5] = '{1'b1, 4'd3, 1'b0, 32'd13, 32'h66778800, 1'b0};
    vecs[6] = '{1'b1, 4'd4, 1'b1, 32'd13, 32'h66778800, 1'b0};
    vecs[7] = '{1'b0, 4'd1, 1'b0, 32'd13, 32'h66778800, 1'b0};

    reset        = 1'b0;
    consume      = 1'b0;
    num_of_ope   = 4'd0;
    redirect     = 1'b0;
    redirect_eip = 32'h0;

    @(negedge clk);
    step();
    step();
    check("rst_ope", ope, 32'h0);
    check("rst_valid", {31'b0, ope_valid}, 32'd0);
    check("rst_eip", eip, 32'h0);
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_err", {31'b0, consume_err}, 32'd0);

    // First word, zero-wait ack.
    reset = 1'b1;
    wait_req(1'b1, 10);
    check("first_addr", mem_addr, 32'h0);
    step();
    check("first_lat_valid", {31'b0, ope_valid}, 32'd0);
    step();
    check("first_ope", ope, 32'h8B5D0855);
    check("first_valid", {31'b0, ope_valid}, 32'd1);
    check("first_eip", eip, 32'h0);

    // Fill to DEPTH: requests must stop.
    repeat (20) step();
    for (int i = 0; i < 5; i++) begin
      check("full_no_req", {31'b0, mem_req}, 32'd0);
      step();
    end
    check("full_ope", ope, 32'h8B5D0855);

    resp_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      consume    = vecs[i].c;
      num_of_ope = vecs[i].n;
      step();
      check($sformatf("vec%0d_eip", i), eip, vecs[i].eip);
      check($sformatf("vec%0d_err", i), {31'b0, consume_err}, {31'b0, vecs[i].err});
      consume    = 1'b0;
      num_of_ope = 4'd0;
      step();
      check($sformatf("vec%0d_ope", i), ope, vecs[i].ope);
      check($sformatf("vec%0d_valid", i), {31'b0, ope_valid}, {31'b0, vecs[i].valid});
      check($sformatf("vec%0d_err_pulse", i), {31'b0, consume_err}, 32'd0);
    end
    check("refill_req", {31'b0, mem_req}, 32'd1);
    check("refill_addr", mem_addr, 32'd16);

    @(posedge clk);
    resp_en = 1'b1;
    @(negedge clk);
    wait_valid(20);
    check("refill_ope", ope, 32'h66778810);
    check("refill_eip", eip, 32'd13);

    repeat (30) step();
    check("full2_no_req", {31'b0, mem_req}, 32'd0);

    // Unaligned redirect.
    redirect     = 1'b1;
    redirect_eip = 32'd6;
    step();
    redirect = 1'b0;
    check("redir_eip", eip, 32'd6);
    step();
    check("redir_req", {31'b0, mem_req}, 32'd1);
    check("redir_addr", mem_addr, 32'd4);
    check("redir_flushed", {31'b0, ope_valid}, 32'd0);
    wait_valid(20);
    check("redir_ope", ope, 32'hC3AA1122);
    check("redir_eip2", eip, 32'd6);

    repeat (30) step();
    check("full3_no_req", {31'b0, mem_req}, 32'd0);

    // Redirect while a slow request is outstanding.
    ack_delay    = 3;
    redirect     = 1'b1;
    redirect_eip = 32'h140;
    step();
    redirect = 1'b0;
    check("slow_eip", eip, 32'h140);
    step();
    check("slow_req", {31'b0, mem_req}, 32'd1);
    check("slow_addr", mem_addr, 32'h140);
    redirect     = 1'b1;
    redirect_eip = 32'h280;
    step();
    redirect = 1'b0;
    check("discard_req_held", {31'b0, mem_req}, 32'd1);
    check("discard_addr_held", mem_addr, 32'h140);
    check("discard_eip", eip, 32'h280);
    check("discard_valid", {31'b0, ope_valid}, 32'd0);
    wait_req(1'b0, 10);
    wait_req(1'b1, 10);
    check("post_discard_addr", mem_addr, 32'h280);
    wait_valid(20);
    check("post_discard_ope", ope, 32'h80818283);
    check("post_discard_eip", eip, 32'h280);

`ifdef PREFETCH_STATS_EN
    check("flush_cnt", flush_cnt, 32'd3);
    check("stall_cnt_min", {31'b0, (stall_cnt >= 32'd3)}, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
